riscv_pc_unit: RTL and testbench

- Parametrised program-counter unit for the kana-riscv fetch stage; successor to the single-target PC register.
- Adds branch, JALR and jump redirect sources, a valid/ready fetch handshake to instruction memory, and stall and redirect-pending logic.
- Supports configurable reset vector and address step, plus misaligned-target detection.
- Sits between decode/execute (redirect sources) and the instruction-memory port.

---
 rtl/riscv_pc_unit_pkg.sv | 18 +
 rtl/riscv_pc_unit_if.sv | 12 +
 rtl/riscv_pc_unit_next.sv | 31 +++
 rtl/riscv_pc_unit.sv | 110 +++++++++++
 tb/tb_riscv_pc_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pc_unit_pkg.sv
// riscv_pc_unit_pkg: next-PC source select, PC unit states and default reset vector.
package riscv_pc_unit_pkg;
    typedef enum logic [2:0] {
        PC_PLUS4,
        PC_J_TARGET,
        PC_BR_TARGET,
        PC_JALR_TARGET,
        PC_HOLD
    } pc_sel_t;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PEND
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/riscv_pc_unit_if.sv
// riscv_pc_unit_if: fetch-address handshake between the PC unit and instruction memory.
interface riscv_pc_unit_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus4;

    modport master (output fetch_valid, pc_out, pc_plus4, input fetch_ready);
    modport slave  (input fetch_valid, pc_out, pc_plus4, output fetch_ready);
endinterface

// File: rtl/riscv_pc_unit_next.sv
// riscv_pc_next: combinational redirect decode, target selection and alignment check.
module riscv_pc_next
    import riscv_pc_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PC_STEP     = 4,
    parameter int ALIGN_CHECK = 1
) (
    input  logic [XLEN-1:0] pc,
    input  pc_sel_t         pc_sel,
    input  logic            br_taken,
    input  logic [XLEN-1:0] target,
    input  logic [XLEN-1:0] pend_tgt,
    output logic            redir,
    output logic            seq,
    output logic [XLEN-1:0] pc_plus,
    output logic [XLEN-1:0] new_tgt,
    output logic [XLEN-1:0] load_tgt,
    output logic            misalign
);
    logic [XLEN-1:0] src;

    assign redir    = pc_sel == PC_J_TARGET || pc_sel == PC_JALR_TARGET || (pc_sel == PC_BR_TARGET && br_taken);
    assign seq      = pc_sel == PC_PLUS4 || (pc_sel == PC_BR_TARGET && !br_taken);
    assign pc_plus  = pc + XLEN'(PC_STEP);
    assign new_tgt  = pc_sel == PC_JALR_TARGET ? {target[XLEN-1:1], 1'b0} : target;
    // A same-cycle redirect supersedes whatever target is latched.
    assign src      = redir ? new_tgt : pend_tgt;
    assign misalign = (ALIGN_CHECK != 0) && (src[1:0] != 2'b00);
    assign load_tgt = misalign ? {src[XLEN-1:2], 2'b00} : src;
endmodule

// File: rtl/riscv_pc_unit.sv
// riscv_pc_unit: fetch-stage PC register with redirect-pending FSM and imem handshake.
// Optional trap entry enabled by defining RISCV_PC_TRAP_EN.
module riscv_pc_unit
    import riscv_pc_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int              PC_STEP      = 4,
    parameter int              ALIGN_CHECK  = 1
) (
    input  logic            clk,
    input  logic            x_reset,
    input  pc_sel_t         pc_sel,
    input  logic            br_taken,
    input  logic [XLEN-1:0] target,
    input  logic            stall,
`ifdef RISCV_PC_TRAP_EN
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    output logic            trap_taken,
`endif
    riscv_pc_unit_if.master fetch,
    output logic            redirect_pending,
    output logic            misalign_err
);
    pc_state_t       state, state_nx;
    logic [XLEN-1:0] pc, pc_nx, pend_tgt, pend_nx, pc_plus, new_tgt, load_tgt;
    logic            redir, seq, misalign, mis_nx, apply, accept;

    riscv_pc_next #(.XLEN(XLEN), .PC_STEP(PC_STEP), .ALIGN_CHECK(ALIGN_CHECK)) u_next (
        .pc       (pc),
        .pc_sel   (pc_sel),
        .br_taken (br_taken),
        .target   (target),
        .pend_tgt (pend_tgt),
        .redir    (redir),
        .seq      (seq),
        .pc_plus  (pc_plus),
        .new_tgt  (new_tgt),
        .load_tgt (load_tgt),
        .misalign (misalign)
    );

    assign fetch.fetch_valid = state != BOOT;
    assign fetch.pc_out      = pc;
    assign fetch.pc_plus4    = pc_plus;
    assign redirect_pending  = state == PEND;
    assign accept            = fetch.fetch_valid & fetch.fetch_ready & ~stall;

`ifdef RISCV_PC_TRAP_EN
    logic trap_nx;
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        pend_nx  = pend_tgt;
        apply    = 1'b0;
        case (state)
            BOOT: state_nx = RUN;
            RUN: begin
                if (redir && fetch.fetch_ready) apply = 1'b1;
                else if (redir) begin
                    pend_nx  = new_tgt;
                    state_nx = PEND;
                end else if (accept && seq) pc_nx = pc_plus;
            end
            PEND: begin
                if (redir) pend_nx = new_tgt;
                // Leaving PEND only needs imem to take the address; stall is irrelevant here.
                if (fetch.fetch_ready) begin
                    apply    = 1'b1;
                    pend_nx  = '0;
                    state_nx = RUN;
                end
            end
            default: state_nx = BOOT;
        endcase
        if (apply) pc_nx = load_tgt;
        mis_nx = apply & misalign;
`ifdef RISCV_PC_TRAP_EN
        trap_nx = trap_req | mis_nx;
        if (trap_nx) begin
            pc_nx    = {trap_vec[XLEN-1:2], 2'b00};
            pend_nx  = '0;
            state_nx = RUN;
        end
`endif
    end

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            pend_tgt     <= '0;
            misalign_err <= 1'b0;
`ifdef RISCV_PC_TRAP_EN
            trap_taken   <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            pend_tgt     <= pend_nx;
            misalign_err <= mis_nx;
`ifdef RISCV_PC_TRAP_EN
            trap_taken   <= trap_nx;
`endif
        end
    end
endmodule

// File: tb/tb_riscv_pc_unit.sv
// tb_riscv_pc_unit: directed and randomized checks of riscv_pc_unit against a cycle-level reference model.
module tb_riscv_pc_unit;
    import riscv_pc_unit_pkg::*;

    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        x_reset = 1'b0;
    pc_sel_t     pc_sel = PC_HOLD;
    logic        br_taken = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] target = '0;
    logic        redirect_pending, misalign_err;
    int          checks = 0;
    int          errors = 0;

    riscv_pc_unit_if #(.XLEN(32)) fif();

`ifdef RISCV_PC_TRAP_EN
    logic        trap_req = 1'b0;
    logic [31:0] trap_vec = 32'h80;
    logic        trap_taken;
`endif

    riscv_pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .PC_STEP(4), .ALIGN_CHECK(1)) dut (
        .clk              (clk),
        .x_reset          (x_reset),
        .pc_sel           (pc_sel),
        .br_taken         (br_taken),
        .target           (target),
        .stall            (stall),
`ifdef RISCV_PC_TRAP_EN
        .trap_req         (trap_req),
        .trap_vec         (trap_vec),
        .trap_taken       (trap_taken),
`endif
        .fetch            (fif),
        .redirect_pending (redirect_pending),
        .misalign_err     (misalign_err)
    );

    always #5 clk = ~clk;

    // Reference model: architectural PC, boot flag, pending-redirect slot, last-cycle pulses.
    logic [31:0] m_pc, m_pt;
    bit          m_boot, m_pend, m_mis, m_trap;

    task automatic model_reset();
        m_pc = RV; m_pt = '0; m_boot = 1; m_pend = 0; m_mis = 0; m_trap = 0;
    endtask

    task automatic model_step();
        bit          redir, load;
        logic [31:0] t, ld;
        redir = pc_sel == PC_J_TARGET || pc_sel == PC_JALR_TARGET || (pc_sel == PC_BR_TARGET && br_taken);
        t     = (pc_sel == PC_JALR_TARGET) ? (target & ~32'h1) : target;
        load  = 0;
        ld    = '0;
        m_mis = 0;
        m_trap = 0;
        if (m_boot) m_boot = 0;
        else if (m_pend) begin
            if (redir) m_pt = t;
            if (fif.fetch_ready) begin ld = m_pt; load = 1; m_pend = 0; end
        end else if (redir) begin
            if (fif.fetch_ready) begin ld = t; load = 1; end
            else begin m_pend = 1; m_pt = t; end
        end else if (fif.fetch_ready && !stall && (pc_sel == PC_PLUS4 || (pc_sel == PC_BR_TARGET && !br_taken)))
            m_pc = m_pc + 32'd4;
        if (load) begin
            m_mis = (ld % 4) != 0;
            m_pc  = ld - (ld % 4);
        end
`ifdef RISCV_PC_TRAP_EN
        if (trap_req || m_mis) begin
            m_pc = trap_vec - (trap_vec % 4); m_pend = 0; m_boot = 0; m_trap = 1;
        end
`endif
    endtask

    task automatic tick(input pc_sel_t s, input bit bt, input logic [31:0] t, input bit st, input bit rdy);
        pc_sel = s; br_taken = bt; target = t; stall = st; fif.fetch_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        x_reset = 0; fif.fetch_ready = 1; pc_sel = PC_PLUS4;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (fif.pc_out !== RV) begin errors++; $display("FAIL reset_pc: got %h expected %h", fif.pc_out, RV); end
        checks++; if (fif.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", fif.fetch_valid); end
        checks++; if (redirect_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", redirect_pending); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
        x_reset = 1;
        #1;
        checks++; if (fif.fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b expected 0", fif.fetch_valid); end
        tick(PC_PLUS4, 0, '0, 0, 1);
        checks++; if (fif.fetch_valid !== 1'b1) begin errors++; $display("FAIL run_valid: got %b expected 1", fif.fetch_valid); end
        checks++; if (fif.pc_out !== 32'h100) begin errors++; $display("FAIL seq0: got %h expected 100", fif.pc_out); end
        tick(PC_PLUS4, 0, '0, 0, 1);
        checks++; if (fif.pc_out !== 32'h104) begin errors++; $display("FAIL seq1: got %h expected 104", fif.pc_out); end
        tick(PC_PLUS4, 0, '0, 0, 1);
        checks++; if (fif.pc_out !== 32'h108) begin errors++; $display("FAIL seq2: got %h expected 108", fif.pc_out); end
        checks++; if (fif.pc_plus4 !== 32'h10C) begin errors++; $display("FAIL pc_plus4: got %h expected 10c", fif.pc_plus4); end
    endtask

    task automatic test_redirect_pending();
        tick(PC_J_TARGET, 0, 32'h200, 0, 1);
        checks++; if (fif.pc_out !== 32'h200) begin errors++; $display("FAIL jump_200: got %h expected 200", fif.pc_out); end
        tick(PC_J_TARGET, 0, 32'h400, 0, 0);
        checks++; if (redirect_pending !== 1'b1) begin errors++; $display("FAIL pend_set: got %b expected 1", redirect_pending); end
        checks++; if (fif.pc_out !== 32'h200) begin errors++; $display("FAIL pend_pc: got %h expected 200", fif.pc_out); end
        tick(PC_PLUS4, 0, '0, 0, 0);
        checks++; if (fif.pc_out !== 32'h200 || redirect_pending !== 1'b1) begin errors++; $display("FAIL pend_hold: got pc %h pend %b expected 200/1", fif.pc_out, redirect_pending); end
        tick(PC_PLUS4, 0, '0, 0, 1);
        checks++; if (fif.pc_out !== 32'h400) begin errors++; $display("FAIL pend_apply: got %h expected 400", fif.pc_out); end
        checks++; if (redirect_pending !== 1'b0) begin errors++; $display("FAIL pend_clear: got %b expected 0", redirect_pending); end
    endtask

    task automatic test_newest_wins();
        tick(PC_J_TARGET, 0, 32'h400, 0, 0);
        tick(PC_JALR_TARGET, 0, 32'h801, 0, 0);
        checks++; if (redirect_pending !== 1'b1) begin errors++; $display("FAIL newest_pend: got %b expected 1", redirect_pending); end
        tick(PC_HOLD, 0, '0, 1, 1);
        checks++; if (fif.pc_out !== 32'h800) begin errors++; $display("FAIL newest_pc: got %h expected 800", fif.pc_out); end
        checks++; if (misalign_err !== 1'b0 || redirect_pending !== 1'b0) begin errors++; $display("FAIL newest_flags: got mis %b pend %b expected 0/0", misalign_err, redirect_pending); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            tick(PC_PLUS4, 0, '0, 1, 1);
            checks++; if (fif.pc_out !== 32'h800) begin errors++; $display("FAIL stall_%0d: got %h expected 800", i, fif.pc_out); end
        end
        tick(PC_BR_TARGET, 1, 32'h40, 1, 1);
        checks++; if (fif.pc_out !== 32'h40) begin errors++; $display("FAIL stall_branch: got %h expected 40", fif.pc_out); end
    endtask

    task automatic test_hold_and_not_taken();
        tick(PC_HOLD, 0, 32'h999, 0, 1);
        checks++; if (fif.pc_out !== 32'h40) begin errors++; $display("FAIL hold: got %h expected 40", fif.pc_out); end
        tick(PC_BR_TARGET, 0, 32'h999, 0, 1);
        checks++; if (fif.pc_out !== 32'h44) begin errors++; $display("FAIL br_not_taken: got %h expected 44", fif.pc_out); end
        tick(PC_PLUS4, 0, '0, 0, 0);
        checks++; if (fif.pc_out !== 32'h44) begin errors++; $display("FAIL not_ready: got %h expected 44", fif.pc_out); end
    endtask

    task automatic test_wrap_misalign();
        tick(PC_J_TARGET, 0, 32'hFFFF_FFFC, 0, 1);
        checks++; if (fif.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected 0", fif.pc_plus4); end
        tick(PC_PLUS4, 0, '0, 0, 1);
        checks++; if (fif.pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", fif.pc_out); end
        tick(PC_J_TARGET, 0, 32'h102, 0, 1);
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b expected 1", misalign_err); end
`ifdef RISCV_PC_TRAP_EN
        checks++; if (fif.pc_out !== 32'h80 || trap_taken !== 1'b1) begin errors++; $display("FAIL misalign_trap: got pc %h trap %b expected 80/1", fif.pc_out, trap_taken); end
`else
        checks++; if (fif.pc_out !== 32'h100) begin errors++; $display("FAIL misalign_pc: got %h expected 100", fif.pc_out); end
`endif
        tick(PC_HOLD, 0, '0, 0, 1);
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_once: got %b expected 0", misalign_err); end
    endtask

    task automatic test_reset_mid_pend();
        tick(PC_J_TARGET, 0, 32'h400, 0, 0);
        checks++; if (redirect_pending !== 1'b1) begin errors++; $display("FAIL mid_pend_set: got %b expected 1", redirect_pending); end
        x_reset = 0;
        model_reset();
        #1;
        checks++; if (redirect_pending !== 1'b0 || fif.fetch_valid !== 1'b0 || fif.pc_out !== RV) begin errors++; $display("FAIL mid_reset: got pend %b valid %b pc %h expected 0/0/%h", redirect_pending, fif.fetch_valid, fif.pc_out, RV); end
        @(posedge clk);
        #1;
        x_reset = 1;
        tick(PC_HOLD, 0, '0, 0, 1);
        tick(PC_HOLD, 0, '0, 0, 1);
        checks++; if (fif.pc_out !== RV || redirect_pending !== 1'b0) begin errors++; $display("FAIL mid_discard: got pc %h pend %b expected %h/0", fif.pc_out, redirect_pending, RV); end
    endtask

`ifdef RISCV_PC_TRAP_EN
    task automatic test_trap();
        tick(PC_J_TARGET, 0, 32'h400, 0, 0);
        trap_req = 1;
        tick(PC_J_TARGET, 0, 32'h400, 0, 0);
        trap_req = 0;
        checks++; if (fif.pc_out !== 32'h80 || redirect_pending !== 1'b0 || trap_taken !== 1'b1) begin errors++; $display("FAIL trap: got pc %h pend %b trap %b expected 80/0/1", fif.pc_out, redirect_pending, trap_taken); end
        tick(PC_HOLD, 0, '0, 0, 1);
        checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL trap_once: got %b expected 0", trap_taken); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] t;
        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
`ifdef RISCV_PC_TRAP_EN
            trap_req = $urandom_range(0, 15) == 0;
`endif
            tick(pc_sel_t'($urandom_range(0, 4)), 1'($urandom), t, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
            checks++; if (fif.pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, fif.pc_out, m_pc); end
            checks++; if (fif.pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4[%0d]: got %h expected %h", i, fif.pc_plus4, m_pc + 32'd4); end
            checks++; if (fif.fetch_valid !== !m_boot) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, fif.fetch_valid, !m_boot); end
            checks++; if (redirect_pending !== m_pend) begin errors++; $display("FAIL rnd_pend[%0d]: got %b expected %b", i, redirect_pending, m_pend); end
            checks++; if (misalign_err !== m_mis) begin errors++; $display("FAIL rnd_mis[%0d]: got %b expected %b", i, misalign_err, m_mis); end
`ifdef RISCV_PC_TRAP_EN
            checks++; if (trap_taken !== m_trap) begin errors++; $display("FAIL rnd_trap[%0d]: got %b expected %b", i, trap_taken, m_trap); end
`endif
        end
`ifdef RISCV_PC_TRAP_EN
        trap_req = 0;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        fif.fetch_ready = 1'b0;
        test_reset();
        test_redirect_pending();
        test_newest_wins();
        test_stall();
        test_hold_and_not_taken();
        test_wrap_misalign();
        test_reset_mid_pend();
`ifdef RISCV_PC_TRAP_EN
        test_trap();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
